// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline front end.
package mips_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned EXC_W  = 5;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  localparam logic [ADDR_W-1:0] PC_RESET_DEFAULT  = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] EXC_ENTRY_DEFAULT = 32'h0000_4180;
  localparam logic [ADDR_W-1:0] IM_LO_DEFAULT     = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] IM_HI_DEFAULT     = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/npc_mux.sv
// Priority selection of the next PC: exception > ERET > branch/jump > sequential.
module npc_mux
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] EXC_ENTRY = EXC_ENTRY_DEFAULT
) (
  input  logic              exc_req,
  input  logic              eret_D,
  input  logic              npc_sel_D,
  input  logic [ADDR_W-1:0] epc,
  input  logic [ADDR_W-1:0] npc_target_D,
  input  logic [ADDR_W-1:0] pc4,
  output logic [ADDR_W-1:0] npc_c
);

  always_comb begin
    npc_c = pc4;
    if (exc_req)        npc_c = EXC_ENTRY;
    else if (eret_D)    npc_c = epc;
    else if (npc_sel_D) npc_c = npc_target_D;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, imem req/ready handshake and AdEL detection.
module if_fetch
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter logic [ADDR_W-1:0] EXC_ENTRY = EXC_ENTRY_DEFAULT,
  parameter logic [ADDR_W-1:0] IM_LO     = IM_LO_DEFAULT,
  parameter logic [ADDR_W-1:0] IM_HI     = IM_HI_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              En,
  input  logic              npc_sel_D,
  input  logic [ADDR_W-1:0] npc_target_D,
  input  logic              bj_D,
  input  logic              exc_req,
  input  logic              eret_D,
  input  logic [ADDR_W-1:0] epc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              fetch_stall,
  output logic [DATA_W-1:0] Instr_F,
  output logic [ADDR_W-1:0] PC_F,
  output logic [ADDR_W-1:0] PC4_F,
  output logic [ADDR_W-1:0] PC8_F,
  output logic [EXC_W-1:0]  ExcCode_F,
  output logic              BJ_F
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] npc;
  logic [ADDR_W-1:0] drain_addr;
  logic              addr_bad;

  assign pc4       = pc + ADDR_W'(4);
  assign addr_bad  = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  assign PC_F      = pc;
  assign PC4_F     = pc4;
  assign PC8_F     = pc + ADDR_W'(8);
  assign ExcCode_F = addr_bad ? EXC_ADEL : EXC_NONE;
  assign BJ_F      = bj_D;

  npc_mux #(
    .EXC_ENTRY (EXC_ENTRY)
  ) u_npc_mux (
    .exc_req      (exc_req),
    .eret_D       (eret_D),
    .npc_sel_D    (npc_sel_D),
    .epc          (epc),
    .npc_target_D (npc_target_D),
    .pc4          (pc4),
    .npc_c        (npc)
  );

  // Exception entry overrides the hazard-unit enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= PC_RESET;
      state      <= FETCH;
      drain_addr <= PC_RESET;
    end else begin
      if (exc_req || En) pc <= npc;
      case (state)
        FETCH: begin
          if (!exc_req && !addr_bad && !imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_ready) begin
            state <= FETCH;
          end else if (exc_req) begin
            state      <= DRAIN;
            drain_addr <= pc;
          end
        end
        DRAIN: begin
          if (imem_ready) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // An outstanding request keeps its address until memory answers, even across a flush.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc;
    fetch_stall = 1'b0;
    Instr_F     = '0;
    case (state)
      FETCH, WAIT: begin
        if (!addr_bad) begin
          imem_req = 1'b1;
          if (!imem_ready)   fetch_stall = 1'b1;
          else if (!exc_req) Instr_F = imem_rdata;
        end
      end
      DRAIN: begin
        imem_req    = 1'b1;
        imem_addr   = drain_addr;
        fetch_stall = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed stimulus queues expected F-stage outputs, a monitor checks them.
module tb_if_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        req;
    logic        bj;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        En;
  logic        npc_sel_D;
  logic [31:0] npc_target_D;
  logic        bj_D;
  logic        exc_req;
  logic        eret_D;
  logic [31:0] epc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        fetch_stall;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] PC4_F;
  logic [31:0] PC8_F;
  logic [4:0]  ExcCode_F;
  logic        BJ_F;

  exp_t        exp_q[$];
  int          n_vec;
  int          n_bad;
  int          stall_cnt;
  logic        mon_on;
  logic [31:0] exp_stall_addr;

  if_fetch dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .En           (En),
    .npc_sel_D    (npc_sel_D),
    .npc_target_D (npc_target_D),
    .bj_D         (bj_D),
    .exc_req      (exc_req),
    .eret_D       (eret_D),
    .epc          (epc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .fetch_stall  (fetch_stall),
    .Instr_F      (Instr_F),
    .PC_F         (PC_F),
    .PC4_F        (PC4_F),
    .PC8_F        (PC8_F),
    .ExcCode_F    (ExcCode_F),
    .BJ_F         (BJ_F)
  );

  // Hazard unit drops En while F stalls; memory word is a fixed tag of the address.
  assign En         = ~fetch_stall;
  assign imem_rdata = imem_addr ^ 32'h2400_0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [31:0] pc, input logic [31:0] instr,
                               input logic [4:0] exc, input logic req, input logic bj);
    exp_t e;
    e.pc = pc; e.instr = instr; e.exc = exc; e.req = req; e.bj = bj;
    exp_q.push_back(e);
  endfunction

  task automatic cyc(input logic r, input logic s, input logic [31:0] t,
                     input logic b, input logic x, input logic e);
    imem_ready = r; npc_sel_D = s; npc_target_D = t; bj_D = b; exc_req = x; eret_D = e;
    @(posedge clk);
    #1;
  endtask

  // Monitor: stalled cycles check the held request, valid cycles pop the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on && reset_n) begin
        if (fetch_stall) begin
          stall_cnt++;
          chk("stall_addr", imem_addr, exp_stall_addr);
          chk("stall_req", 32'(imem_req), 32'd1);
          chk("stall_instr", Instr_F, 32'd0);
        end else if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: got pc %h, expected no instruction", PC_F);
        end else begin
          e = exp_q.pop_front();
          chk("PC_F", PC_F, e.pc);
          chk("PC4_F", PC4_F, e.pc + 32'd4);
          chk("PC8_F", PC8_F, e.pc + 32'd8);
          chk("Instr_F", Instr_F, e.instr);
          chk("ExcCode_F", 32'(ExcCode_F), 32'(e.exc));
          chk("imem_req", 32'(imem_req), 32'(e.req));
          chk("BJ_F", 32'(BJ_F), 32'(e.bj));
          if (e.req) chk("imem_addr", imem_addr, e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0; n_bad = 0; stall_cnt = 0; mon_on = 1'b1;
    exp_stall_addr = 32'h0;
    reset_n = 1'b0; imem_ready = 1'b1; npc_sel_D = 1'b0; npc_target_D = 32'h0;
    bj_D = 1'b1; exc_req = 1'b0; eret_D = 1'b0; epc = 32'h0000_3100;

    push(32'h3000, 32'h2400_3000, 5'd0, 1'b1, 1'b0);
    push(32'h3004, 32'h2400_3004, 5'd0, 1'b1, 1'b0);
    push(32'h3008, 32'h2400_3008, 5'd0, 1'b1, 1'b0);
    push(32'h300C, 32'h2400_300C, 5'd0, 1'b1, 1'b0);
    push(32'h3010, 32'h2400_3010, 5'd0, 1'b1, 1'b0);
    push(32'h3014, 32'h2400_3014, 5'd0, 1'b1, 1'b0);
    push(32'h3018, 32'h2400_3018, 5'd0, 1'b1, 1'b0);
    push(32'h301C, 32'h2400_301C, 5'd0, 1'b1, 1'b0);
    push(32'h3020, 32'h2400_3020, 5'd0, 1'b1, 1'b1);
    push(32'h3400, 32'h2400_3400, 5'd0, 1'b1, 1'b0);
    push(32'h3404, 32'h2400_3404, 5'd0, 1'b1, 1'b0);
    push(32'h3002, 32'h0,         5'd4, 1'b0, 1'b0);
    push(32'h4180, 32'h2400_4180, 5'd0, 1'b1, 1'b0);
    push(32'h3100, 32'h0,         5'd0, 1'b1, 1'b0);
    push(32'h4180, 32'h2400_4180, 5'd0, 1'b1, 1'b0);
    push(32'h4184, 32'h2400_4184, 5'd0, 1'b1, 1'b0);
    push(32'h3000, 32'h2400_3000, 5'd0, 1'b1, 1'b0);
    push(32'h3004, 32'h2400_3004, 5'd0, 1'b1, 1'b0);
    push(32'hFFFF_FFFC, 32'h0,    5'd4, 1'b0, 1'b0);
    push(32'h3008, 32'h2400_3008, 5'd0, 1'b1, 1'b0);
    push(32'h300C, 32'h2400_300C, 5'd0, 1'b1, 1'b0);

    // Reset state, ready high then low; BJ_F follows bj_D.
    #7;
    chk("rst_pc", PC_F, 32'h3000);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_stall_rdy", 32'(fetch_stall), 32'd0);
    chk("rst_instr_rdy", Instr_F, 32'h2400_3000);
    chk("rst_exc", 32'(ExcCode_F), 32'd0);
    chk("rst_bj", 32'(BJ_F), 32'd1);
    imem_ready = 1'b0;
    #1;
    chk("rst_stall_nrdy", 32'(fetch_stall), 32'd1);
    chk("rst_instr_nrdy", Instr_F, 32'd0);
    imem_ready = 1'b1; bj_D = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    cyc(1, 0, 32'h0, 0, 0, 0);          // 3000
    cyc(1, 0, 32'h0, 0, 0, 0);          // 3004
    cyc(1, 0, 32'h0, 0, 0, 0);          // 3008
    cyc(1, 0, 32'h0, 0, 0, 0);          // 300C
    exp_stall_addr = 32'h3010;
    cyc(0, 0, 32'h0, 0, 0, 0);          // 3010 wait x3
    cyc(0, 0, 32'h0, 0, 0, 0);
    cyc(0, 0, 32'h0, 0, 0, 0);
    cyc(1, 0, 32'h0, 0, 0, 0);          // 3010 delivered
    cyc(1, 0, 32'h0, 0, 0, 0);          // 3014
    cyc(1, 0, 32'h0, 0, 0, 0);          // 3018
    cyc(1, 0, 32'h0, 0, 0, 0);          // 301C
    cyc(1, 1, 32'h3400, 1, 0, 0);       // 3020 delay slot, branch taken
    cyc(1, 0, 32'h0, 0, 0, 0);          // 3400
    cyc(1, 1, 32'h3002, 0, 0, 0);       // 3404 -> misaligned target
    cyc(1, 1, 32'h3040, 0, 0, 0);       // 3002 AdEL, no stall
    exp_stall_addr = 32'h3040;
    cyc(0, 0, 32'h0, 0, 0, 0);          // 3040 -> WAIT
    cyc(0, 0, 32'h0, 0, 1, 0);          // exception in WAIT -> DRAIN
    cyc(0, 0, 32'h0, 0, 0, 0);          // DRAIN
    cyc(1, 0, 32'h0, 0, 0, 0);          // DRAIN, stale word dropped
    cyc(1, 1, 32'h3400, 0, 0, 1);       // 4180, ERET beats branch
    cyc(1, 1, 32'h3400, 0, 1, 1);       // 3100, exception beats ERET
    cyc(1, 0, 32'h0, 0, 0, 0);          // 4180
    cyc(1, 0, 32'h0, 0, 0, 0);          // 4184
    exp_stall_addr = 32'h4188;
    cyc(0, 0, 32'h0, 0, 0, 0);          // 4188 -> WAIT
    cyc(0, 0, 32'h0, 0, 0, 0);          // WAIT

    // Reset in the middle of WAIT.
    reset_n = 1'b0;
    imem_ready = 1'b1;
    #2;
    chk("midrst_pc", PC_F, 32'h3000);
    chk("midrst_addr", imem_addr, 32'h3000);
    chk("midrst_stall", 32'(fetch_stall), 32'd0);
    chk("midrst_instr", Instr_F, 32'h2400_3000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    cyc(1, 0, 32'h0, 0, 0, 0);          // 3000
    cyc(1, 1, 32'hFFFF_FFFC, 0, 0, 0);  // 3004 -> top of address space
    cyc(1, 1, 32'h3008, 0, 0, 0);       // FFFFFFFC AdEL, wrapped PC4/PC8
    cyc(1, 0, 32'h0, 0, 0, 0);          // 3008
    cyc(1, 0, 32'h0, 0, 0, 0);          // 300C
    mon_on = 1'b0;

    chk("pending_expect", 32'(exp_q.size()), 32'd0);
    chk("stall_cycles", 32'(stall_cnt), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage for the 5-stage MIPS pipeline with CP0 exceptions. Owns the PC register, computes the next PC (sequential, branch/jump target, exception entry, ERET return), runs a req/ready handshake with instruction memory, and detects fetch-address exceptions. Its outputs are the F-stage values sampled by the IF/ID pipeline register.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000, PC value after reset
- `EXC_ENTRY`, 32'h0000_4180, exception handler address
- `IM_LO` / `IM_HI`, 32'h0000_3000 / 32'h0000_6FFC, legal fetch range (inclusive)

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `En` in 1: PC advance enable from the hazard unit. Same signal that drives the IF/ID enable.
- `npc_sel_D` in 1: the D-stage branch/jump is taken.
- `npc_target_D` in 32: branch/jump target.
- `bj_D` in 1: the D-stage instruction is a branch or jump.
- `exc_req` in 1: CP0 takes an exception or interrupt this cycle.
- `eret_D` in 1: ERET is in D.
- `epc` in 32: return address from CP0.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_ready` in 1: read data valid.
- `imem_rdata` in 32: instruction word.
- `fetch_stall` out 1: F has no valid instruction this cycle; the hazard unit must drop `En`.
- `Instr_F`, `PC_F`, `PC4_F`, `PC8_F` out 32: instruction, PC, PC+4, PC+8.
- `ExcCode_F` out 5: 0 = none, 4 = AdEL.
- `BJ_F` out 1: the instruction in F is a delay slot.

## Operation
- The PC register resets to `PC_RESET`.
- `PC_F` = pc, `PC4_F` = pc+4, `PC8_F` = pc+8. All are 32-bit modulo adds.
- `BJ_F` = `bj_D`, passed through combinationally.
- Address check:
  - The address is bad if pc[1:0] != 0, pc < `IM_LO`, or pc > `IM_HI`.
  - For a bad address: `ExcCode_F` = 4, `Instr_F` = 0, `imem_req` = 0, `fetch_stall` = 0. The instruction is treated as valid immediately.
- Next-PC priority, highest first:
  1. `exc_req` → `EXC_ENTRY`
  2. `eret_D` → `epc`
  3. `npc_sel_D` → `npc_target_D`
  4. pc+4
- The PC updates only on a cycle where `En` = 1, or where `exc_req` = 1 (exception entry ignores `En`).
- FSM states: FETCH, WAIT, DRAIN. Reset state is FETCH.
- FETCH:
  - If the address is good, drive `imem_req` = 1 and `imem_addr` = pc.
  - If `imem_ready` = 1: `Instr_F` = `imem_rdata`, `fetch_stall` = 0, stay in FETCH.
  - Otherwise: `fetch_stall` = 1, `Instr_F` = 0, go to WAIT.
- WAIT:
  - Hold `imem_req` = 1 and keep `imem_addr` stable.
  - When `imem_ready` = 1: `Instr_F` = rdata, `fetch_stall` = 0, go to FETCH.
- `exc_req` during WAIT when `imem_ready` = 0:
  - PC ← `EXC_ENTRY`; go to DRAIN.
  - DRAIN keeps `imem_req` = 1 at the old address (latched in `drain_addr`), `fetch_stall` = 1, `Instr_F` = 0.
  - On `imem_ready`, the returned word is discarded and the FSM goes to FETCH.
- `exc_req` in WAIT with `imem_ready` = 1 the same cycle: the word is discarded, PC ← `EXC_ENTRY`, go to FETCH.
- `exc_req` in FETCH: the current word is discarded, PC ← `EXC_ENTRY`, stay in FETCH.
- Redirect inputs (`npc_sel_D`, `eret_D`) are sampled only on `En` = 1 edges. While `fetch_stall` = 1, D is frozen, so these inputs are stable.

## Timing
- Reset values:
  - pc = `PC_RESET`; state FETCH.
  - `imem_req` = 1, `imem_addr` = 32'h3000.
  - `fetch_stall` = !`imem_ready`; `Instr_F` = `imem_rdata` when ready, else 0.
  - `ExcCode_F` = 0, `BJ_F` = `bj_D`.
- Zero-wait memory (`imem_ready` in the request cycle): one instruction per cycle with no stall.
- N-wait memory: `fetch_stall` is high for N cycles, and the instruction is presented in cycle N+1.
- `reset_n` assertion mid-WAIT or mid-DRAIN: immediate return to FETCH with pc = `PC_RESET`. The memory side must also be reset.
- Wrap-around: pc+4 and pc+8 at 32'hFFFF_FFFC wrap to 0 and 4. That pc is out of range, so it raises AdEL with no request.

## Structure
- Shared package `mips_pkg`:
  - `EXC_ADEL` = 5'd4
  - `EXC_NONE` = 5'd0
  - `PC_RESET`, `EXC_ENTRY`, `IM_LO`, `IM_HI` defaults
  - FSM state enum `fetch_state_t`
- One sub-module `npc_mux`: combinational priority selection of the next PC. The PC register and FSM stay in `if_fetch`.

## Test plan
- Reset release with zero-wait memory: `PC_F` = 3000, 3004, 3008 on consecutive cycles; `fetch_stall` = 0 throughout.
- `imem_ready` held low 3 cycles at pc = 3010: `fetch_stall` = 1 for 3 cycles with `imem_addr` = 3010 stable; then `Instr_F` = rdata; pc advances to 3014.
- Taken branch: `npc_sel_D` = 1, target = 3400, `bj_D` = 1 at pc = 3020. `BJ_F` = 1 for the 3020 delay slot, then `PC_F` = 3400.
- pc = 3002 via branch target: `ExcCode_F` = 4, `imem_req` = 0, `Instr_F` = 0, no stall.
- `exc_req` in WAIT at pc = 3040, with ready arriving 2 cycles later: DRAIN for 2 cycles; old data discarded; next fetch at 4180.
- `eret_D` and `npc_sel_D` together, with `epc` = 3100: PC = 3100. With `exc_req` also high: PC = 4180.
